// File: rtl/dcache_responder.sv
// Data-port responder: word-addressed backing store behind a direct-mapped
// tag array that only models hit/miss timing. A miss stalls the core for
// MISS_LAT cycles, then performs the latched access and returns the word.
//
// state  | meaning
// -------+----------------------------------------------------------------
// S_IDLE | accepting requests; hits complete in one cycle
// S_MISS | stalling the core while the wait counter runs down to zero
module dcache_responder #(
    parameter int DWIDTH          = 32,
    parameter int MEM_AWIDTH      = 12,
    parameter int LINE_WORDS_LOG2 = 2,
    parameter int INDEX_BITS      = 6,
    parameter int MISS_LAT        = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DWIDTH-1:0] addr,
    input  logic [3:0]        we,
    input  logic              re,
    input  logic [DWIDTH-1:0] din,
    output logic [DWIDTH-1:0] dout,
    output logic              stall,
    output logic [31:0]       access_count,
    output logic [31:0]       miss_count
);
    localparam int OFF_W   = LINE_WORDS_LOG2 + 2;
    localparam int TAG_LSB = INDEX_BITS + OFF_W;
    localparam int TAG_W   = DWIDTH - TAG_LSB;
    localparam int LINES   = 1 << INDEX_BITS;
    localparam int DEPTH   = 1 << MEM_AWIDTH;
    localparam int CNT_W   = (MISS_LAT > 1) ? $clog2(MISS_LAT) : 1;

    typedef enum logic {S_IDLE, S_MISS} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DWIDTH-1:0]   laddr_q, laddr_d;
    logic [3:0]          lwe_q, lwe_d;
    logic [DWIDTH-1:0]   ldin_q, ldin_d;
    logic [DWIDTH-1:0]   dout_q, dout_d;
    logic [31:0]         acc_q, acc_d;
    logic [31:0]         miss_q, miss_d;
    logic [LINES-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_q [LINES];
    logic [DWIDTH-1:0]   mem_q [DEPTH];

    logic [DWIDTH-1:0]     sel_addr, sel_din, rd_word, merged;
    logic [3:0]            sel_we;
    logic [MEM_AWIDTH-1:0] word_idx;
    logic [INDEX_BITS-1:0] line_idx;
    logic [TAG_W-1:0]      req_tag;
    logic                  hit, req_valid, mem_we, tag_we;
    logic                  unused_addr_lsb;

    // While stalled, the access being completed is the latched one; in idle
    // the live request is decoded directly.
    always_comb begin
        sel_addr = addr;
        sel_we   = we;
        sel_din  = din;
        if (state_q == S_MISS) begin
            sel_addr = laddr_q;
            sel_we   = lwe_q;
            sel_din  = ldin_q;
        end
    end

    assign word_idx        = sel_addr[MEM_AWIDTH+1:2];
    assign line_idx        = sel_addr[TAG_LSB-1:OFF_W];
    assign req_tag         = sel_addr[DWIDTH-1:TAG_LSB];
    assign rd_word         = mem_q[word_idx];
    assign hit             = valid_q[line_idx] && (tag_q[line_idx] == req_tag);
    assign req_valid       = (state_q == S_IDLE) && (re || (we != 4'b0000));
    assign unused_addr_lsb = ^sel_addr[1:0];

    // Byte-lane merge: the word as it will read after this access's write.
    always_comb begin
        merged = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (sel_we[i]) merged[8*i +: 8] = sel_din[8*i +: 8];
        end
    end

    // Next-state, counters and write strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        laddr_d = laddr_q;
        lwe_d   = lwe_q;
        ldin_d  = ldin_q;
        dout_d  = dout_q;
        acc_d   = acc_q;
        miss_d  = miss_q;
        mem_we  = 1'b0;
        tag_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    acc_d = acc_q + 32'd1;
                    if (hit) begin
                        mem_we = (we != 4'b0000);
                        dout_d = merged;
                    end else begin
                        miss_d  = miss_q + 32'd1;
                        laddr_d = addr;
                        lwe_d   = we;
                        ldin_d  = din;
                        cnt_d   = CNT_W'(MISS_LAT - 1);
                        state_d = S_MISS;
                    end
                end
            end
            S_MISS: begin
                if (cnt_q == '0) begin
                    tag_we  = 1'b1;
                    mem_we  = (lwe_q != 4'b0000);
                    dout_d  = merged;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state, counters, latched request and valid bits; reset aborts any miss.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            laddr_q <= '0;
            lwe_q   <= '0;
            ldin_q  <= '0;
            dout_q  <= '0;
            acc_q   <= '0;
            miss_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            laddr_q <= laddr_d;
            lwe_q   <= lwe_d;
            ldin_q  <= ldin_d;
            dout_q  <= dout_d;
            acc_q   <= acc_d;
            miss_q  <= miss_d;
            if (tag_we) valid_q[line_idx] <= 1'b1;
        end
    end

    // Tag storage; contents are only meaningful under a set valid bit.
    always_ff @(posedge clk) begin
        if (tag_we) tag_q[line_idx] <= req_tag;
    end

    // Backing store; deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[word_idx] <= merged;
    end

    assign dout         = dout_q;
    assign stall        = (state_q == S_MISS);
    assign access_count = acc_q;
    assign miss_count   = miss_q;
endmodule

// File: tb/tb_dcache_responder.sv
// Bench for dcache_responder: a reference model predicts hit/miss, stall
// length, counters and read data; predicted words go through a queue.
module tb_dcache_responder;
    localparam int MISS_LAT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [3:0]  we;
    logic        re;
    logic [31:0] din;
    logic [31:0] dout;
    logic        stall;
    logic [31:0] access_count;
    logic [31:0] miss_count;

    dcache_responder #(.MISS_LAT(MISS_LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .we           (we),
        .re           (re),
        .din          (din),
        .dout         (dout),
        .stall        (stall),
        .access_count (access_count),
        .miss_count   (miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        bit          known;
    } sb_t;

    sb_t         exp_q[$];
    logic [31:0] mmem [int];
    bit          mvalid [64];
    logic [21:0] mtag [64];
    logic [31:0] mac, mmc;
    logic [31:0] last_dout;
    bit          last_known;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
        mac        = '0;
        mmc        = '0;
        last_dout  = '0;
        last_known = 1'b1;
        exp_q.delete();
    endtask

    // Drive one request starting #1 after a rising edge; returns #1 after the
    // edge at which the result is visible, leaving the request on the pins.
    task automatic req(input logic [31:0] a, input logic [3:0] w, input logic r,
                       input logic [31:0] d);
        int          wi;
        int          li;
        logic [21:0] tg;
        bit          hit;
        sb_t         e;
        sb_t         got;
        logic [31:0] old;
        wi  = int'(a[13:2]);
        li  = int'(a[9:4]);
        tg  = a[31:10];
        hit = mvalid[li] && (mtag[li] == tg);
        if (w == 4'hF) begin
            e.known = 1'b1;
            e.data  = d;
        end else if (mmem.exists(wi)) begin
            old = mmem[wi];
            for (int i = 0; i < 4; i++) if (w[i]) old[8*i +: 8] = d[8*i +: 8];
            e.known = 1'b1;
            e.data  = old;
        end else begin
            e.known = 1'b0;
            e.data  = '0;
        end
        if (w != 4'h0) begin
            if (e.known) mmem[wi] = e.data;
            else if (mmem.exists(wi)) mmem.delete(wi);
        end
        mac = mac + 32'd1;
        if (!hit) begin
            mmc        = mmc + 32'd1;
            mvalid[li] = 1'b1;
            mtag[li]   = tg;
        end
        exp_q.push_back(e);

        addr = a; we = w; re = r; din = d;
        @(posedge clk); #1;
        if (!hit) begin
            for (int i = 0; i < MISS_LAT; i++) begin
                chk("stall_during_miss", {31'd0, stall}, 32'd1);
                @(posedge clk); #1;
            end
        end
        chk("stall_done", {31'd0, stall}, 32'd0);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            got = exp_q.pop_front();
            if (got.known) chk("dout", dout, got.data);
            last_dout  = got.data;
            last_known = got.known;
        end
        chk("access_count", access_count, mac);
        chk("miss_count", miss_count, mmc);
    endtask

    task automatic idle(input int n);
        addr = '0; we = 4'h0; re = 1'b0; din = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk("idle_stall", {31'd0, stall}, 32'd0);
            if (last_known) chk("idle_dout_hold", dout, last_dout);
            chk("idle_access", access_count, mac);
        end
    endtask

    task automatic do_reset();
        addr = '0; we = 4'h0; re = 1'b0; din = '0;
        reset = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_dout", dout, 32'd0);
        chk("rst_access", access_count, 32'd0);
        chk("rst_miss", miss_count, 32'd0);
        reset = 1'b1;
    endtask

    logic [31:0] pool [6];

    initial begin
        pool = '{32'h10, 32'h20, 32'h40, 32'h420, 32'h810, 32'h30};
        addr = '0; we = 4'h0; re = 1'b0; din = '0;
        reset = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // Seed two words, then reset: backing store must survive.
        req(32'h10, 4'hF, 1'b0, 32'hCAFE_F00D);
        req(32'h40, 4'hF, 1'b0, 32'h55AA_55AA);
        idle(1);
        do_reset();

        // Cold read miss.
        req(32'h10, 4'h0, 1'b1, 32'h0);
        idle(2);

        // Store miss then read hit, byte write hit then immediate read.
        req(32'h20, 4'hF, 1'b0, 32'hDEAD_BEEF);
        req(32'h20, 4'h0, 1'b1, 32'h0);
        req(32'h20, 4'b0100, 1'b0, 32'h00AB_0000);
        req(32'h20, 4'h0, 1'b1, 32'h0);
        chk("byte_merge", dout, 32'hDEAB_BEEF);
        idle(2);

        // Conflict on one line index.
        req(32'h420, 4'h0, 1'b1, 32'h0);
        req(32'h20, 4'h0, 1'b1, 32'h0);
        req(32'h420, 4'h0, 1'b1, 32'h0);
        idle(1);

        // Reset during the second stall cycle of a store miss.
        addr = 32'h40; we = 4'hF; re = 1'b0; din = 32'h1234_5678;
        @(posedge clk); #1;
        chk("abort_stall1", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        chk("abort_stall2", {31'd0, stall}, 32'd1);
        reset = 1'b0;
        model_reset();
        #1;
        chk("abort_stall_drop", {31'd0, stall}, 32'd0);
        chk("abort_access", access_count, 32'd0);
        chk("abort_miss", miss_count, 32'd0);
        chk("abort_dout", dout, 32'd0);
        addr = '0; we = 4'h0; din = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        req(32'h40, 4'h0, 1'b1, 32'h0);
        chk("abort_prestore", dout, 32'h55AA_55AA);

        // Access counter wrap on hits.
        idle(1);
        dut.acc_q <= 32'hFFFF_FFFE;
        mac = 32'hFFFF_FFFE;
        #1;
        req(32'h40, 4'h0, 1'b1, 32'h0);
        req(32'h40, 4'h0, 1'b1, 32'h0);
        chk("wrap_zero", access_count, 32'h0);
        req(32'h40, 4'h0, 1'b1, 32'h0);
        idle(1);

        // Mixed random traffic over a small conflicting address pool.
        for (int k = 0; k < 40; k++) begin
            logic [3:0]  w;
            logic        r;
            logic [31:0] a;
            a = pool[$urandom_range(5)];
            w = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
            r = (w == 4'h0) ? 1'b1 : 1'($urandom_range(1));
            req(a, w, r, $urandom);
            if ($urandom_range(3) == 0) idle(1);
        end
        idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
